// File: rtl/clock_set_if.sv
// Button, carry and counter-control signals exchanged between the clock_set_ctrl
// sequencer and the surrounding counter chain and button front end.
interface clock_set_if;
    logic       EN1HZ;
    logic       EN_RPT;
    logic       MODE_BTN;
    logic       UP_BTN;
    logic       SEC_CA;
    logic       MIN_CA;
    logic       SEC_EN;
    logic       SEC_CLR;
    logic       MIN_EN;
    logic       HOUR_EN;
    logic [1:0] MODE;
    logic       BLK_H;
    logic       BLK_M;
    logic       BLK_S;

    modport master (
        output EN1HZ, EN_RPT, MODE_BTN, UP_BTN, SEC_CA, MIN_CA,
        input  SEC_EN, SEC_CLR, MIN_EN, HOUR_EN, MODE, BLK_H, BLK_M, BLK_S
    );

    modport slave (
        input  EN1HZ, EN_RPT, MODE_BTN, UP_BTN, SEC_CA, MIN_CA,
        output SEC_EN, SEC_CLR, MIN_EN, HOUR_EN, MODE, BLK_H, BLK_M, BLK_S
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode controller and time-setting sequencer for a 24-hour clock: routes the 1 Hz
// enable and carries in normal mode, steps one field per UP press/repeat in set modes.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT   = 30,
    parameter int unsigned RPT_START = 4
) (
    input  logic        CLK,
    input  logic        RST,
    clock_set_if.slave  bus
);

    typedef enum logic [1:0] {
        NORM     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] RPT_MAX = 4'(RPT_START);

    mode_t      state;
    logic       mode_q;
    logic       up_q;
    logic       inc;
    logic       phase;
    logic [7:0] to_cnt;
    logic [3:0] rpt_cnt;

    logic       mode_rise;
    logic       up_rise;
    logic       in_set;
    logic       timeout_hit;
    logic       chg;
    logic       rpt_fire;

    assign mode_rise = bus.MODE_BTN & ~mode_q;
    assign up_rise   = bus.UP_BTN & ~up_q;
    assign in_set    = (state != NORM);
    // An UP edge in the same cycle as the last idle tick restarts the idle window.
    assign timeout_hit = in_set & ~up_rise & bus.EN1HZ & (to_cnt == TO_LAST);
    assign chg         = mode_rise | timeout_hit;
    assign rpt_fire    = bus.UP_BTN & bus.EN_RPT & (rpt_cnt == RPT_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= NORM;
            mode_q  <= 1'b0;
            up_q    <= 1'b0;
            inc     <= 1'b0;
            phase   <= 1'b0;
            to_cnt  <= '0;
            rpt_cnt <= '0;
        end else begin
            mode_q <= bus.MODE_BTN;
            up_q   <= bus.UP_BTN;

            if (mode_rise) begin
                case (state)
                    NORM:     state <= SET_HOUR;
                    SET_HOUR: state <= SET_MIN;
                    SET_MIN:  state <= SET_SEC;
                    default:  state <= NORM;
                endcase
            end else if (timeout_hit) begin
                state <= NORM;
            end

            // A mode edge wins over a coincident UP edge; the UP edge is dropped.
            inc <= in_set & ~mode_rise & (up_rise | rpt_fire);

            if (!in_set || mode_rise || up_rise || chg)
                to_cnt <= '0;
            else if (bus.EN1HZ)
                to_cnt <= to_cnt + 8'd1;

            if (!in_set || !bus.UP_BTN || chg)
                rpt_cnt <= '0;
            else if (bus.EN_RPT && (rpt_cnt != RPT_MAX))
                rpt_cnt <= rpt_cnt + 4'd1;

            if (!in_set || chg)
                phase <= 1'b0;
            else if (bus.EN1HZ)
                phase <= ~phase;
        end
    end

    // Routing depends only on registered state, so SEC_CA -> SEC_EN cannot loop.
    always_comb begin
        bus.SEC_EN  = 1'b0;
        bus.SEC_CLR = 1'b0;
        bus.MIN_EN  = 1'b0;
        bus.HOUR_EN = 1'b0;
        if (!RST) begin
            case (state)
                NORM: begin
                    bus.SEC_EN  = bus.EN1HZ;
                    bus.MIN_EN  = bus.SEC_CA;
                    bus.HOUR_EN = bus.MIN_CA;
                end
                SET_HOUR: bus.HOUR_EN = inc;
                SET_MIN:  bus.MIN_EN  = inc;
                default:  bus.SEC_CLR = inc;
            endcase
        end
    end

    assign bus.MODE  = state;
    assign bus.BLK_H = phase & (state == SET_HOUR);
    assign bus.BLK_M = phase & (state == SET_MIN);
    assign bus.BLK_S = phase & (state == SET_SEC);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the mode/set rules.
module tb_clock_set_ctrl;

    localparam int TIMEOUT   = 30;
    localparam int RPT_START = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    clock_set_if bus();

    clock_set_ctrl #(.TIMEOUT(TIMEOUT), .RPT_START(RPT_START)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state: current mode number, pending step pulse, seconds
    // without a button edge, repeat ticks seen while UP held, blink phase, last buttons.
    int m_mode, m_idle, m_held;
    bit m_inc, m_phase, m_pmb, m_pub;

    // Observed {SEC_EN,SEC_CLR,MIN_EN,HOUR_EN,MODE[1:0],BLK_H,BLK_M,BLK_S}
    logic [8:0] obs;

    task automatic cyc(input bit r, input bit e1, input bit er, input bit mb,
                       input bit ub, input bit sca, input bit mca);
        logic [8:0] e;
        bit mr, ur, set, chg, n_inc, n_phase;
        int n_mode, n_idle, n_held;
        RST = r;
        bus.EN1HZ = e1; bus.EN_RPT = er; bus.MODE_BTN = mb; bus.UP_BTN = ub;
        bus.SEC_CA = sca; bus.MIN_CA = mca;
        #1;
        if (r) begin
            m_mode = 0; m_idle = 0; m_held = 0;
            m_inc = 0; m_phase = 0; m_pmb = 0; m_pub = 0;
        end
        e = '0;
        if (!r) begin
            case (m_mode)
                0: begin e[8] = e1; e[6] = sca; e[5] = mca; end
                1: e[5] = m_inc;
                2: e[6] = m_inc;
                default: e[7] = m_inc;
            endcase
            e[4:3] = 2'(m_mode);
            e[2] = m_phase && (m_mode == 1);
            e[1] = m_phase && (m_mode == 2);
            e[0] = m_phase && (m_mode == 3);
        end
        obs = {bus.SEC_EN, bus.SEC_CLR, bus.MIN_EN, bus.HOUR_EN, bus.MODE,
               bus.BLK_H, bus.BLK_M, bus.BLK_S};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL cycle t=%0t outputs got=%b expected=%b", $time, obs, e);
        end
        if (!r) begin
            mr  = mb && !m_pmb;
            ur  = ub && !m_pub;
            set = (m_mode != 0);
            n_mode = m_mode;
            if (mr) n_mode = (m_mode + 1) % 4;
            else if (set && !ur && e1 && (m_idle + 1 == TIMEOUT)) n_mode = 0;
            chg     = (n_mode != m_mode);
            n_inc   = set && !mr && (ur || (ub && er && m_held == RPT_START));
            n_idle  = (!set || mr || ur || chg) ? 0 : m_idle + int'(e1);
            n_held  = (!set || !ub || chg) ? 0 :
                      ((m_held + int'(er) > RPT_START) ? RPT_START : m_held + int'(er));
            n_phase = (!set || chg) ? 1'b0 : (m_phase ^ e1);
        end
        @(posedge CLK);
        #1;
        if (!r) begin
            m_mode = n_mode; m_idle = n_idle; m_held = n_held;
            m_inc = n_inc; m_phase = n_phase; m_pmb = mb; m_pub = ub;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic press_mode();
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        int pulses;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 9'd0) begin
            errors++; $display("FAIL reset_outputs got=%b expected=%b", obs, 9'd0);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0); pulses += int'(obs[8]);
            cyc(0, 0, 0, 0, 0, 0, 0); pulses += int'(obs[8]);
        end
        checks++;
        if (pulses != 3) begin
            errors++; $display("FAIL norm_sec_en_count got=%0d expected=3", pulses);
        end
        checks++;
        if (obs[4:0] !== 5'd0) begin
            errors++; $display("FAIL norm_mode_blk got=%b expected=00000", obs[4:0]);
        end
    endtask

    task automatic test_mode_steps();
        int exp_mode [4] = '{1, 2, 3, 0};
        cyc(0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (obs[6:5] !== 2'b11) begin
            errors++; $display("FAIL norm_carry got=%b expected=11", obs[6:5]);
        end
        for (int i = 0; i < 4; i++) begin
            press_mode();
            checks++;
            if (int'(obs[4:3]) != exp_mode[i]) begin
                errors++;
                $display("FAIL mode_step%0d got=%0d expected=%0d", i, obs[4:3], exp_mode[i]);
            end
        end
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs[4:3] !== 2'd1) begin
            errors++; $display("FAIL mode_hold got=%0d expected=1", obs[4:3]);
        end
    endtask

    task automatic test_set_min();
        logic [3:0] min_pat, hour_pat;
        press_mode();
        idle(1);
        min_pat = '0; hour_pat = '0;
        cyc(0, 0, 0, 0, 1, 0, 0); min_pat[0] = obs[6]; hour_pat[0] = obs[5];
        cyc(0, 0, 0, 0, 1, 0, 0); min_pat[1] = obs[6]; hour_pat[1] = obs[5];
        cyc(0, 0, 0, 0, 0, 0, 0); min_pat[2] = obs[6]; hour_pat[2] = obs[5];
        cyc(0, 0, 0, 0, 0, 0, 0); min_pat[3] = obs[6]; hour_pat[3] = obs[5];
        checks++;
        if (min_pat !== 4'b0010) begin
            errors++; $display("FAIL set_min_pulse got=%b expected=0010", min_pat);
        end
        checks++;
        if (hour_pat !== 4'b0000) begin
            errors++; $display("FAIL set_min_no_hour got=%b expected=0000", hour_pat);
        end
    endtask

    task automatic test_simultaneous();
        int hp;
        press_mode(); press_mode(); press_mode();
        checks++;
        if (obs[4:3] !== 2'd1) begin
            errors++; $display("FAIL sim_setup_mode got=%0d expected=1", obs[4:3]);
        end
        hp = 0;
        cyc(0, 0, 0, 1, 1, 0, 0); hp += int'(obs[5]);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0); hp += int'(obs[5]);
        end
        checks++;
        if (obs[4:3] !== 2'd2) begin
            errors++; $display("FAIL sim_mode got=%0d expected=2", obs[4:3]);
        end
        checks++;
        if (hp != 0) begin
            errors++; $display("FAIL sim_no_hour got=%0d expected=0", hp);
        end
    endtask

    task automatic test_back_to_back_repeat();
        int held_cnt, post_cnt, run, max_run;
        press_mode(); press_mode(); press_mode();
        held_cnt = 0; run = 0; max_run = 0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(0, 0, (k == 0), 0, 1, 0, 0);
                held_cnt += int'(obs[5]);
                run = obs[5] ? run + 1 : 0;
                if (run > max_run) max_run = run;
            end
        end
        cyc(0, 0, 0, 0, 1, 0, 0); held_cnt += int'(obs[5]);
        cyc(0, 0, 0, 0, 1, 0, 0); held_cnt += int'(obs[5]);
        post_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 0); post_cnt += int'(obs[5]);
        end
        checks++;
        if (held_cnt != 7) begin
            errors++; $display("FAIL repeat_count got=%0d expected=7", held_cnt);
        end
        checks++;
        if (max_run != 1) begin
            errors++; $display("FAIL repeat_width got=%0d expected=1", max_run);
        end
        checks++;
        if (post_cnt != 0) begin
            errors++; $display("FAIL repeat_release got=%0d expected=0", post_cnt);
        end
    endtask

    task automatic test_set_sec_timeout();
        int clr_cnt, sec_en_cnt;
        int mode_after [31];
        press_mode(); press_mode();
        clr_cnt = 0; sec_en_cnt = 0;
        cyc(0, 0, 0, 0, 1, 0, 0); clr_cnt += int'(obs[7]); sec_en_cnt += int'(obs[8]);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0); clr_cnt += int'(obs[7]); sec_en_cnt += int'(obs[8]);
        end
        for (int k = 1; k <= 30; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            if (k < 30) sec_en_cnt += int'(obs[8]);
            cyc(0, 0, 0, 0, 0, 0, 0);
            mode_after[k] = int'(obs[4:3]);
        end
        checks++;
        if (clr_cnt != 1) begin
            errors++; $display("FAIL sec_clr_count got=%0d expected=1", clr_cnt);
        end
        checks++;
        if (sec_en_cnt != 0) begin
            errors++; $display("FAIL set_sec_en got=%0d expected=0", sec_en_cnt);
        end
        checks++;
        if (mode_after[29] != 3) begin
            errors++; $display("FAIL timeout_early got=%0d expected=3", mode_after[29]);
        end
        checks++;
        if (mode_after[30] != 0) begin
            errors++; $display("FAIL timeout_return got=%0d expected=0", mode_after[30]);
        end
    endtask

    task automatic test_reset_mid_set();
        press_mode(); press_mode();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs[1] !== 1'b1 || obs[4:3] !== 2'd2) begin
            errors++; $display("FAIL blink_setup got=%b expected=mode 10 blk_m 1", obs);
        end
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (bus.MODE !== 2'd0 || bus.BLK_M !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=mode %0d blk_m %b expected=mode 0 blk_m 0",
                     bus.MODE, bus.BLK_M);
        end
        @(posedge CLK);
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (obs[8] !== 1'b1 || obs[6] !== 1'b1 || obs[4:3] !== 2'd0) begin
            errors++; $display("FAIL post_reset_routing got=%b expected=1x1x00xxx", obs);
        end
    endtask

    task automatic test_random();
        bit mb, ub;
        mb = 0; ub = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) mb = ~mb;
            if ($urandom_range(0, 4) == 0) ub = ~ub;
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 3) == 0), mb, ub,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bus.EN1HZ = 0; bus.EN_RPT = 0; bus.MODE_BTN = 0; bus.UP_BTN = 0;
        bus.SEC_CA = 0; bus.MIN_CA = 0;
        m_mode = 0; m_idle = 0; m_held = 0;
        m_inc = 0; m_phase = 0; m_pmb = 0; m_pub = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_mode_steps();
        test_set_min();
        test_simultaneous();
        test_back_to_back_repeat();
        test_set_sec_timeout();
        test_reset_mid_set();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
